// File: rtl/if_stage.sv
// Fetch stage and IF/ID pipeline register for the RV32I core.
// Optional misaligned-redirect tagging is enabled by defining IF_MISALIGN_CHK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PCF,
  output logic [31:0] instructionD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD
`ifdef IF_MISALIGN_CHK_EN
  ,output logic       misalignD
`endif
);

  localparam int unsigned XLEN = 32;

  logic            stall;
  logic            accept;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;

  // A decode stall also freezes fetch so no returned word is lost.
  assign stall     = StallF | StallD;
  assign imem_req  = rst_n & ~stall;
  assign accept    = imem_req & imem_ready;
  assign pc_plus4  = pc_q + XLEN'(4);
  assign imem_addr = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (PCSrcE)      pc_d = PCTargetE & ~XLEN'(3);
    else if (stall)  pc_d = pc_q;
    else if (accept) pc_d = pc_plus4;
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (FlushD || PCSrcE) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (StallD) begin
      valid_d = valid_q;
    end else if (accept) begin
      instr_d = imem_rdata;
      pcd_d   = pc_q;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign PCF          = pc_q;
  assign instructionD = instr_q;
  assign PCD          = pcd_q;
  assign PCPlus4D     = pcp4_q;
  assign validD       = valid_q;

`ifdef IF_MISALIGN_CHK_EN
  logic mis_f_q, mis_f_d;
  logic mis_d_q, mis_d_d;

  // Flag survives until the first instruction fetched after the bad redirect.
  always_comb begin
    mis_f_d = mis_f_q;
    if (PCSrcE)      mis_f_d = |PCTargetE[1:0];
    else if (accept) mis_f_d = 1'b0;
  end

  always_comb begin
    mis_d_d = mis_d_q;
    if (FlushD || PCSrcE) mis_d_d = 1'b0;
    else if (StallD)      mis_d_d = mis_d_q;
    else if (accept)      mis_d_d = mis_f_q;
    else                  mis_d_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_f_q <= 1'b0;
      mis_d_q <= 1'b0;
    end else begin
      mis_f_q <= mis_f_d;
      mis_d_q <= mis_d_d;
    end
  end

  assign misalignD = mis_d_q;
`endif

endmodule
